// File: rtl/mem_bus_pkg.sv
// Shared widths, FSM state encoding and request op encoding for the
// cache-to-memory bus arbiter.
package mem_bus_pkg;

  localparam int DEF_ADDR_W  = 28;
  localparam int DEF_BLOCK_W = 128;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SERVE_I = 3'd1,
    SERVE_D = 3'd2,
    RESP_I  = 3'd3,
    RESP_D  = 3'd4
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

endpackage

// File: rtl/mem_arb_port.sv
// One requester side of the arbiter: request decode, captured op,
// registered refill data and the combinational stall back to the cache.
module mem_arb_port
  import mem_bus_pkg::*;
#(
  parameter int BLOCK_W   = DEF_BLOCK_W,
  parameter bit HAS_WRITE = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rd,
  input  logic               wr,
  input  logic               grant,
  input  logic               done,
  input  logic               resp,
  input  logic [BLOCK_W-1:0] mem_rdata,
  output logic               req,
  output op_t                op_next,
  output logic               busywait,
  output logic [BLOCK_W-1:0] rdata
);

  logic wr_en;
  op_t  op;

  // A write wins over a simultaneous read; the read must be re-issued.
  assign wr_en    = HAS_WRITE && wr;
  assign req      = rd || wr_en;
  assign op_next  = wr_en ? OP_WR : OP_RD;
  assign busywait = req && !resp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op    <= OP_RD;
      rdata <= '0;
    end else begin
      if (grant) op <= op_next;
      if (done && op == OP_RD) rdata <= mem_rdata;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Serialises i_cache refills and d_cache refills/writebacks onto one
// main-memory port; the data side always wins a tie.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int BLOCK_W = DEF_BLOCK_W
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               I_READ,
  input  logic [ADDR_W-1:0]  I_ADDRESS,
  output logic [BLOCK_W-1:0] I_READDATA,
  output logic               I_BUSYWAIT,
  input  logic               D_READ,
  input  logic               D_WRITE,
  input  logic [ADDR_W-1:0]  D_ADDRESS,
  input  logic [BLOCK_W-1:0] D_WRITEDATA,
  output logic [BLOCK_W-1:0] D_READDATA,
  output logic               D_BUSYWAIT,
  output logic               M_READ,
  output logic               M_WRITE,
  output logic [ADDR_W-1:0]  M_ADDRESS,
  output logic [BLOCK_W-1:0] M_WRITEDATA,
  input  logic [BLOCK_W-1:0] M_READDATA,
  input  logic               M_BUSYWAIT
);

  state_t state;
  logic   first;
  logic   i_req, d_req;
  op_t    i_op_next, d_op_next;
  logic   serve_done;

  // first masks a stale M_BUSYWAIT=0 seen in the cycle the request goes out.
  assign serve_done = !first && !M_BUSYWAIT;

  mem_arb_port #(.BLOCK_W(BLOCK_W), .HAS_WRITE(1'b0)) u_i_port (
    .clk      (CLK),
    .rst_n    (RESET),
    .rd       (I_READ),
    .wr       (1'b0),
    .grant    (state == IDLE && !d_req && i_req),
    .done     (state == SERVE_I && serve_done),
    .resp     (state == RESP_I),
    .mem_rdata(M_READDATA),
    .req      (i_req),
    .op_next  (i_op_next),
    .busywait (I_BUSYWAIT),
    .rdata    (I_READDATA)
  );

  mem_arb_port #(.BLOCK_W(BLOCK_W), .HAS_WRITE(1'b1)) u_d_port (
    .clk      (CLK),
    .rst_n    (RESET),
    .rd       (D_READ),
    .wr       (D_WRITE),
    .grant    (state == IDLE && d_req),
    .done     (state == SERVE_D && serve_done),
    .resp     (state == RESP_D),
    .mem_rdata(M_READDATA),
    .req      (d_req),
    .op_next  (d_op_next),
    .busywait (D_BUSYWAIT),
    .rdata    (D_READDATA)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= IDLE;
      first       <= 1'b0;
      M_READ      <= 1'b0;
      M_WRITE     <= 1'b0;
      M_ADDRESS   <= '0;
      M_WRITEDATA <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_req) begin
            state       <= SERVE_D;
            first       <= 1'b1;
            M_READ      <= (d_op_next == OP_RD);
            M_WRITE     <= (d_op_next == OP_WR);
            M_ADDRESS   <= D_ADDRESS;
            M_WRITEDATA <= D_WRITEDATA;
          end else if (i_req) begin
            state     <= SERVE_I;
            first     <= 1'b1;
            M_READ    <= (i_op_next == OP_RD);
            M_WRITE   <= (i_op_next == OP_WR);
            M_ADDRESS <= I_ADDRESS;
          end
        end
        SERVE_I, SERVE_D: begin
          first <= 1'b0;
          if (serve_done) begin
            M_READ  <= 1'b0;
            M_WRITE <= 1'b0;
            state   <= (state == SERVE_I) ? RESP_I : RESP_D;
          end
        end
        RESP_I, RESP_D: state <= IDLE;
        default:        state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench: table of cache requests against a latency-programmable
// memory model, with per-port expected-response queues and corner sequences.
module tb_mem_bus_arbiter;

  logic         CLK;
  logic         RESET;
  logic         I_READ;
  logic [27:0]  I_ADDRESS;
  logic [127:0] I_READDATA;
  logic         I_BUSYWAIT;
  logic         D_READ, D_WRITE;
  logic [27:0]  D_ADDRESS;
  logic [127:0] D_WRITEDATA;
  logic [127:0] D_READDATA;
  logic         D_BUSYWAIT;
  logic         M_READ, M_WRITE;
  logic [27:0]  M_ADDRESS;
  logic [127:0] M_WRITEDATA;
  logic [127:0] M_READDATA;
  logic         M_BUSYWAIT;

  mem_bus_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
    .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS), .D_WRITEDATA(D_WRITEDATA),
    .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
    .M_READ(M_READ), .M_WRITE(M_WRITE), .M_ADDRESS(M_ADDRESS), .M_WRITEDATA(M_WRITEDATA),
    .M_READDATA(M_READDATA), .M_BUSYWAIT(M_BUSYWAIT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  localparam logic [127:0] BLK_I  = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
  localparam logic [127:0] BLK_30 = 128'h3030_1111_2222_3333_4444_5555_6666_7777;
  localparam logic [127:0] BLK_A5 = {16{8'hA5}};
  localparam logic [127:0] BLK_5A = {16{8'h5A}};
  localparam logic [127:0] BLK_40 = {4{32'h4040_BEEF}};

  // memory model: busy until the request has been up for lat_cfg cycles
  logic [127:0] mem [0:255];
  int           cnt = 0;
  int           lat_cfg = 0;
  logic         pre_we = 1'b0;
  logic [7:0]   pre_addr = '0;
  logic [127:0] pre_data = '0;

  always @(posedge CLK) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    if (M_READ || M_WRITE) begin
      cnt <= cnt + 1;
      if (M_WRITE && !M_BUSYWAIT) mem[M_ADDRESS[7:0]] <= M_WRITEDATA;
    end else begin
      cnt <= 0;
    end
  end

  assign M_BUSYWAIT = (M_READ || M_WRITE) ? (cnt < lat_cfg - 1) : 1'b1;
  assign M_READDATA = mem[M_ADDRESS[7:0]];

  // bus-wide watchdogs: address must not change mid-request, never read+write
  logic [27:0] prev_addr = '0;
  logic        prev_act = 1'b0;
  bit          glitch = 1'b0;
  bit          both = 1'b0;

  always @(negedge CLK) begin
    if (M_READ && M_WRITE) both <= 1'b1;
    if (prev_act && (M_READ || M_WRITE) && M_ADDRESS != prev_addr) glitch <= 1'b1;
    prev_act  <= M_READ || M_WRITE;
    prev_addr <= M_ADDRESS;
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [127:0] data;
    int           n;
    bit           mrd;
    bit           mwr;
  } exp_t;

  exp_t q_i[$];
  exp_t q_d[$];

  logic [127:0] ref_mem [0:255];
  logic [127:0] last_i = '0;
  logic [127:0] last_d = '0;

  typedef struct {
    bit           is_d;
    bit           rd;
    bit           wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
    int           lat;
    int           exp_n;
    bit           exp_mrd;
    bit           exp_mwr;
  } vec_t;

  vec_t vecs[8];

  task automatic preload(input logic [7:0] a, input logic [127:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge CLK); #1;
    pre_we = 1'b0;
    ref_mem[a] = d;
  endtask

  // Drive one request, wait for release, then drop it on the following edge.
  task automatic run_req(input bit is_d, input bit rd, input bit wr,
                         input logic [27:0] addr, input logic [127:0] wdata,
                         input int exp_n, input bit exp_mrd, input bit exp_mwr,
                         input string tag);
    exp_t         e;
    int           n;
    bit           done, saw_rd, saw_wr, data_bad;
    logic [127:0] rdata_seen;
    e.n   = exp_n;
    e.mrd = exp_mrd;
    e.mwr = exp_mwr;
    if (wr) begin
      e.data = is_d ? last_d : last_i;
      ref_mem[addr[7:0]] = wdata;
    end else begin
      e.data = ref_mem[addr[7:0]];
      if (is_d) last_d = e.data; else last_i = e.data;
    end
    if (is_d) q_d.push_back(e); else q_i.push_back(e);

    if (is_d) begin
      D_READ = rd; D_WRITE = wr; D_ADDRESS = addr; D_WRITEDATA = wdata;
    end else begin
      I_READ = rd; I_ADDRESS = addr;
    end

    n = 0; done = 0; saw_rd = 0; saw_wr = 0; data_bad = 0; rdata_seen = '0;
    while (!done && n < 200) begin
      @(posedge CLK);
      n++;
      @(negedge CLK);
      if ((M_READ || M_WRITE) && M_ADDRESS == addr) begin
        saw_rd |= M_READ;
        saw_wr |= M_WRITE;
        if (M_WRITE && M_WRITEDATA != wdata) data_bad = 1;
      end
      if (!(is_d ? D_BUSYWAIT : I_BUSYWAIT)) begin
        done = 1;
        rdata_seen = is_d ? D_READDATA : I_READDATA;
      end
    end
    @(posedge CLK); #1;
    if (is_d) begin D_READ = 0; D_WRITE = 0; end
    else I_READ = 0;

    if (is_d) e = q_d.pop_front(); else e = q_i.pop_front();
    chk({tag, ".release_cycle"}, 128'(n), 128'(e.n));
    chk({tag, ".readdata"}, rdata_seen, e.data);
    chk({tag, ".m_read_seen"}, 128'(saw_rd), 128'(e.mrd));
    chk({tag, ".m_write_seen"}, 128'(saw_wr), 128'(e.mwr));
    if (wr) chk({tag, ".m_writedata_bad"}, 128'(data_bad), 128'(0));
  endtask

  initial begin
    int  n;
    bit  done, saw_wr;

    vecs[0] = '{1'b0, 1'b1, 1'b0, 28'h10, 128'h0,  5, 6, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 28'h20, BLK_A5,  3, 4, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 28'h30, 128'h0,  2, 3, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 28'h20, 128'h0,  4, 5, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 28'h24, BLK_5A,  3, 4, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 28'h24, 128'h0,  0, 3, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 28'h24, 128'h0,  0, 3, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 28'h30, 128'h0,  7, 8, 1'b1, 1'b0};

    RESET = 1'b0;
    I_READ = 0; I_ADDRESS = '0;
    D_READ = 0; D_WRITE = 0; D_ADDRESS = '0; D_WRITEDATA = '0;

    preload(8'h10, BLK_I);
    preload(8'h30, BLK_30);

    chk("rst.m_read", 128'(M_READ), 128'(0));
    chk("rst.m_write", 128'(M_WRITE), 128'(0));
    chk("rst.m_address", 128'(M_ADDRESS), 128'(0));
    chk("rst.m_writedata", M_WRITEDATA, 128'(0));
    chk("rst.i_readdata", I_READDATA, 128'(0));
    chk("rst.d_readdata", D_READDATA, 128'(0));
    I_READ = 1; D_WRITE = 1; #1;
    chk("rst.i_busywait_req", 128'(I_BUSYWAIT), 128'(1));
    chk("rst.d_busywait_req", 128'(D_BUSYWAIT), 128'(1));
    I_READ = 0; D_WRITE = 0; #1;
    chk("rst.i_busywait_idle", 128'(I_BUSYWAIT), 128'(0));

    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK); #1;

    for (int i = 0; i < 8; i++) begin
      lat_cfg = vecs[i].lat;
      run_req(vecs[i].is_d, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
              vecs[i].exp_n, vecs[i].exp_mrd, vecs[i].exp_mwr, $sformatf("vec%0d", i));
    end

    // Simultaneous I and D: D first, then I after one idle cycle.
    lat_cfg = 3;
    fork
      run_req(1'b1, 1'b1, 1'b0, 28'h30, 128'h0, 4, 1'b1, 1'b0, "both.d");
      run_req(1'b0, 1'b1, 1'b0, 28'h10, 128'h0, 9, 1'b1, 1'b0, "both.i");
    join

    // Reset pulsed in the third SERVE_D cycle of a writeback.
    lat_cfg = 8;
    D_WRITE = 1; D_ADDRESS = 28'h40; D_WRITEDATA = BLK_40;
    @(posedge CLK);
    @(posedge CLK);
    @(posedge CLK);
    #2 RESET = 1'b0;
    #1;
    chk("midrst.m_write", 128'(M_WRITE), 128'(0));
    chk("midrst.m_read", 128'(M_READ), 128'(0));
    chk("midrst.m_address", 128'(M_ADDRESS), 128'(0));
    chk("midrst.d_readdata", D_READDATA, 128'(0));
    chk("midrst.i_readdata", I_READDATA, 128'(0));
    chk("midrst.d_busywait", 128'(D_BUSYWAIT), 128'(1));
    @(posedge CLK); #1;
    chk("midrst.d_busywait_held", 128'(D_BUSYWAIT), 128'(1));
    chk("midrst.m_write_held", 128'(M_WRITE), 128'(0));
    @(negedge CLK);
    RESET = 1'b1;
    last_i = '0; last_d = '0;
    n = 0; done = 0; saw_wr = 0;
    while (!done && n < 200) begin
      @(posedge CLK);
      n++;
      @(negedge CLK);
      if (M_WRITE && M_ADDRESS == 28'h40) saw_wr = 1;
      if (!D_BUSYWAIT) done = 1;
    end
    @(posedge CLK); #1;
    D_WRITE = 0;
    ref_mem[8'h40] = BLK_40;
    chk("midrst.restart_cycle", 128'(n), 128'(9));
    chk("midrst.restart_m_write", 128'(saw_wr), 128'(1));

    lat_cfg = 2;
    run_req(1'b1, 1'b1, 1'b0, 28'h40, 128'h0, 3, 1'b1, 1'b0, "post.d");
    run_req(1'b0, 1'b1, 1'b0, 28'h10, 128'h0, 3, 1'b1, 1'b0, "post.i");

    chk("bus.addr_glitch", 128'(glitch), 128'(0));
    chk("bus.read_and_write", 128'(both), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
